// File: rtl/led_ctrl_pkg.sv
// led_ctrl_pkg: shared mode encodings and register addresses for the LED controller
package led_ctrl_pkg;
   typedef enum logic [1:0] {
      LED_OFF   = 2'd0,
      LED_ON    = 2'd1,
      LED_BLINK = 2'd2,
      LED_PWM   = 2'd3
   } led_mode_t;
   localparam int ADDR_DIRECT    = 0;
   localparam int ADDR_BLINK_DIV = 1;
   localparam int ADDR_CH_BASE   = 2;
endpackage

// File: rtl/led_channel.sv
// led_channel: per-LED mode/duty registers and lit-value selection
module led_channel
   import led_ctrl_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                direct_we,
   input  logic                direct_bit,
   input  logic                cfg_we,
   input  logic [PWM_BITS+1:0] cfg,
   input  logic                blink_phase,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output led_mode_t           mode,
   output logic [PWM_BITS-1:0] duty,
   output logic                lit
);
   always_ff @(posedge clk) begin
      if (reset) begin
         mode <= LED_OFF;
         duty <= '0;
      end else if (cfg_we) begin
         mode <= led_mode_t'(cfg[1:0]);
         duty <= cfg[PWM_BITS+1:2];
      end else if (direct_we) begin
         mode <= direct_bit ? LED_ON : LED_OFF;
      end
   end
   always_comb begin
      lit = mode == LED_ON    ? 1'b1 :
            mode == LED_BLINK ? !blink_phase :
            mode == LED_PWM   ? (pwm_cnt < duty) : 1'b0;
   end
endmodule

// File: rtl/led_ctrl.sv
// led_ctrl: bus-mapped LED controller with OFF/ON/BLINK/PWM channels and readback
module led_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int NUM_LEDS        = 6,
   parameter int PWM_BITS        = 8,
   parameter int DATA_W          = 24,
   parameter int ADDR_W          = 5,
   parameter int BLINK_DIV_RESET = 13499999,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                write_enable,
   input  logic                read_enable,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   data_in,
   output logic [DATA_W-1:0]   data_out,
   output logic [NUM_LEDS-1:0] led
);
   led_mode_t             mode [NUM_LEDS];
   logic [PWM_BITS-1:0]   duty [NUM_LEDS];
   logic [NUM_LEDS-1:0]   lit;
   logic [DATA_W-1:0]     blink_div, blink_cnt, rd_data;
   logic                  blink_phase;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic                  direct_we, div_we;
   assign direct_we = write_enable && addr == ADDR_W'(ADDR_DIRECT);
   assign div_we    = write_enable && addr == ADDR_W'(ADDR_BLINK_DIV);
   for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
      led_channel #(.PWM_BITS(PWM_BITS)) u_ch (
         .clk        (clk),
         .reset      (reset),
         .direct_we  (direct_we),
         .direct_bit (data_in[i]),
         .cfg_we     (write_enable && addr == ADDR_W'(ADDR_CH_BASE + i)),
         .cfg        (data_in[PWM_BITS+1:0]),
         .blink_phase(blink_phase),
         .pwm_cnt    (pwm_cnt),
         .mode       (mode[i]),
         .duty       (duty[i]),
         .lit        (lit[i])
      );
   end
   always_comb begin
      rd_data = '0;
      if (addr == ADDR_W'(ADDR_DIRECT))
         for (int i = 0; i < NUM_LEDS; i++) rd_data[i] = mode[i] == LED_ON;
      if (addr == ADDR_W'(ADDR_BLINK_DIV)) rd_data = blink_div;
      for (int i = 0; i < NUM_LEDS; i++)
         if (addr == ADDR_W'(ADDR_CH_BASE + i)) rd_data = DATA_W'({duty[i], mode[i]});
   end
   // a BLINK_DIV write restarts the blink period in the lit phase
   always_ff @(posedge clk) begin
      if (reset) begin
         blink_div   <= DATA_W'(BLINK_DIV_RESET);
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         pwm_cnt     <= '0;
         data_out    <= '0;
         led         <= ACTIVE_LOW != 0 ? '1 : '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         led     <= ACTIVE_LOW != 0 ? ~lit : lit;
         if (read_enable) data_out <= rd_data;
         if (div_we) begin
            blink_div   <= data_in;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
         end else if (blink_cnt == blink_div) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed scoreboard bench for led_ctrl
module tb_led_ctrl;
   typedef struct {
      string       tag;
      logic [23:0] exp;
   } item_t;
   logic        clk = 0, reset = 1, write_enable = 0, read_enable = 0;
   logic [4:0]  addr = '0;
   logic [23:0] data_in = '0;
   logic [23:0] data_out;
   logic [5:0]  led;
   item_t       sb[$];
   int          passes = 0, fails = 0, checks = 0;
   led_ctrl dut (
      .clk(clk), .reset(reset), .write_enable(write_enable), .read_enable(read_enable),
      .addr(addr), .data_in(data_in), .data_out(data_out), .led(led)
   );
   always #5 clk = ~clk;
   task automatic expect_val(input string tag, input logic [23:0] exp);
      item_t it;
      it.tag = tag;
      it.exp = exp;
      sb.push_back(it);
   endtask
   task automatic check(input logic [23:0] obs);
      item_t it;
      checks++;
      if (sb.size() == 0) begin
         fails++;
         $error("FAIL scoreboard_empty: got %0h required entry", obs);
      end else begin
         it = sb.pop_front();
         assert (obs === it.exp) passes++;
         else begin
            fails++;
            $error("FAIL %s: got %0h required %0h", it.tag, obs, it.exp);
         end
      end
   endtask
   task automatic wr(input logic [4:0] a, input logic [23:0] d);
      @(negedge clk);
      addr = a; data_in = d; write_enable = 1;
      @(negedge clk);
      write_enable = 0;
   endtask
   task automatic rd(input logic [4:0] a, input logic [23:0] exp, input string tag);
      @(negedge clk);
      addr = a; read_enable = 1;
      expect_val(tag, exp);
      @(negedge clk);
      read_enable = 0;
      check(data_out);
   endtask
   task automatic led_is(input logic [5:0] exp, input string tag);
      expect_val(tag, {18'd0, exp});
      check({18'd0, led});
   endtask
   task automatic pwm_scan(input int lows_exp, input int falls_exp, input string tag);
      logic s [256];
      int lows = 0, falls = 0;
      expect_val({tag, "_lows"}, 24'(lows_exp));
      expect_val({tag, "_runs"}, 24'(falls_exp));
      for (int j = 0; j < 256; j++) begin
         @(negedge clk);
         s[j] = led[2];
      end
      for (int j = 0; j < 256; j++) begin
         if (!s[j]) lows++;
         if (!s[j] && s[(j + 255) % 256]) falls++;
      end
      check(24'(lows));
      check(24'(falls));
   endtask
   initial begin
      repeat (3) @(negedge clk);
      reset = 0;
      led_is(6'h3F, "reset_led");
      expect_val("reset_data_out", 24'd0);
      check(data_out);
      rd(5'd1, 24'd13499999, "reset_blink_div");
      wr(5'd0, 24'h000001);
      led_is(6'h3F, "direct_latency");
      @(negedge clk);
      led_is(6'h3E, "direct_1");
      wr(5'd0, 24'h000000);
      wr(5'd0, 24'hFFFF0A);
      @(negedge clk);
      led_is(6'h35, "direct_0a");
      rd(5'd0, 24'h00000A, "read_direct");
      @(negedge clk);
      addr = 5'd0; data_in = 24'h3F; write_enable = 1; read_enable = 1;
      expect_val("rw_same_addr", 24'h00000A);
      @(negedge clk);
      write_enable = 0; read_enable = 0;
      check(data_out);
      rd(5'd0, 24'h00003F, "read_after_rw");
      wr(5'd0, 24'h0);
      wr(5'd4, (24'd64 << 2) | 24'd3);
      rd(5'd4, 24'd259, "ch2_cfg_read");
      pwm_scan(64, 1, "pwm64");
      wr(5'd0, 24'h04);
      rd(5'd4, (24'd64 << 2) | 24'd1, "direct_keeps_duty");
      wr(5'd4, 24'd3);
      pwm_scan(0, 0, "pwm0");
      wr(5'd4, (24'd255 << 2) | 24'd3);
      pwm_scan(255, 1, "pwm255");
      wr(5'd4, 24'd0);
      wr(5'd2, 24'd2);
      wr(5'd1, 24'd3);
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         expect_val($sformatf("blink_s%0d", j), ((j / 4) % 2 == 0) ? 24'd0 : 24'd1);
         check({23'd0, led[0]});
      end
      repeat (4) @(negedge clk);
      reset = 1; write_enable = 1; addr = 5'd3; data_in = 24'd1;
      @(negedge clk);
      reset = 0; write_enable = 0;
      led_is(6'h3F, "reset_mid_led");
      rd(5'd3, 24'd0, "reset_lost_write");
      rd(5'd1, 24'd13499999, "reset_div");
      wr(5'd2, 24'd2);
      @(negedge clk);
      led_is(6'h3E, "blink_phase0_after_reset");
      wr(5'd31, 24'hFFFFFF);
      rd(5'd31, 24'd0, "addr31_read");
      rd(5'd8, 24'd0, "addr8_read");
      rd(5'd2, 24'd2, "addr31_ch0_kept");
      rd(5'd0, 24'd0, "addr31_direct_kept");
      led_is(6'h3E, "addr31_led");
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
